// File: rtl/fft_bar_sequencer.sv
// Reads one FFT magnitude frame (Left bins, then Right bins), log-scales each bin
// to a bar height and hands the bars to the spectrum bar writer one at a time.
module fft_bar_sequencer #(
    parameter int NUM_BARS = 400,
    parameter int BAR_MAX  = 96,
    parameter int RD_LAT   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        frame_start_i,
    output logic [9:0]  rd_addr_o,
    output logic        rd_en_o,
    input  logic [15:0] rd_data_i,
    input  logic        wr_busy_i,
    output logic        wr_start_o,
    output logic [6:0]  wr_bar_o,
    output logic        wr_lr_change_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        overrun_o,
    output logic        ch_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_LRCHG, S_GAP, S_READ, S_WAITRD,
        S_CALC, S_START, S_HOLD, S_WAITEND, S_NEXT
    } state_e;

    state_e      state_q;
    logic [8:0]  bin_q;
    logic        ch_q;
    logic [15:0] mag_q;
    logic [1:0]  wait_cnt_q;
    logic [9:0]  rd_addr_q;
    logic        rd_en_q;
    logic        wr_start_q;
    logic [6:0]  wr_bar_q;
    logic        wr_lr_q;
    logic        busy_q;
    logic        done_q;
    logic        overrun_q;

    // Log scale: 6 steps per octave plus 2 per quarter-octave from the bits under the MSB.
    logic [3:0]  msb_idx;
    logic [15:0] norm;
    logic [6:0]  bar_raw;
    logic [6:0]  bar_d;

    always_comb begin
        msb_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (mag_q[i]) msb_idx = 4'(i);
        end
        norm    = mag_q << (4'd15 - msb_idx);
        bar_raw = ({3'b000, msb_idx} * 7'd6) + {4'b0000, norm[14:13], 1'b0};
        if (mag_q == 16'd0)
            bar_d = 7'd0;
        else if (bar_raw > 7'(BAR_MAX))
            bar_d = 7'(BAR_MAX);
        else
            bar_d = bar_raw;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            ch_q       <= 1'b0;
            mag_q      <= '0;
            wait_cnt_q <= '0;
            rd_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            wr_start_q <= 1'b0;
            wr_bar_q   <= '0;
            wr_lr_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rd_en_q    <= 1'b0;
            wr_start_q <= 1'b0;
            wr_lr_q    <= 1'b0;
            done_q     <= 1'b0;
            if (frame_start_i && busy_q) overrun_q <= 1'b1;

            case (state_q)
                // Busy is still high during the FrameDone cycle, so a start there is rejected.
                S_IDLE: begin
                    busy_q <= 1'b0;
                    if (frame_start_i && !busy_q) begin
                        busy_q  <= 1'b1;
                        state_q <= S_LRCHG;
                    end
                end
                S_LRCHG: begin
                    if (!wr_busy_i) begin
                        wr_lr_q <= 1'b1;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= {ch_q, bin_q};
                    state_q   <= S_READ;
                end
                S_READ: begin
                    wait_cnt_q <= 2'd1;
                    state_q    <= S_WAITRD;
                end
                S_WAITRD: begin
                    if (wait_cnt_q == 2'(RD_LAT)) begin
                        mag_q   <= rd_data_i;
                        state_q <= S_CALC;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 2'd1;
                    end
                end
                S_CALC: begin
                    wr_bar_q   <= bar_d;
                    wr_start_q <= 1'b1;
                    state_q    <= S_START;
                end
                S_START: state_q <= S_HOLD;
                // Writer Busy only rises the cycle after Start; skip that stale low sample.
                S_HOLD:  state_q <= S_WAITEND;
                S_WAITEND: begin
                    if (!wr_busy_i) state_q <= S_NEXT;
                end
                S_NEXT: begin
                    if (bin_q < 9'(NUM_BARS - 1)) begin
                        bin_q     <= bin_q + 9'd1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= {ch_q, bin_q + 9'd1};
                        state_q   <= S_READ;
                    end else if (!ch_q) begin
                        ch_q    <= 1'b1;
                        bin_q   <= '0;
                        state_q <= S_LRCHG;
                    end else begin
                        done_q  <= 1'b1;
                        ch_q    <= 1'b0;
                        bin_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_addr_o      = rd_addr_q;
    assign rd_en_o        = rd_en_q;
    assign wr_start_o     = wr_start_q;
    assign wr_bar_o       = wr_bar_q;
    assign wr_lr_change_o = wr_lr_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = done_q;
    assign overrun_o      = overrun_q;
    assign ch_o           = ch_q;

endmodule

// File: tb/tb_fft_bar_sequencer.sv
// Scoreboard bench for fft_bar_sequencer: stimulus pushes expected writer events and
// RAM addresses, a negedge monitor pops and compares whenever the DUT emits one.
module tb_fft_bar_sequencer;

    localparam int NB      = 400;
    localparam int WR_LEN  = 3;
    localparam int EV_LR   = 0;
    localparam int EV_BAR  = 1;
    localparam int EV_DONE = 2;

    // Hand-computed directed vectors: address, magnitude, expected bar height.
    localparam int NT = 12;
    localparam int T_ADDR [NT] = '{'h000, 'h001, 'h002, 'h003, 'h004, 'h005,
                                   'h006, 'h0A0, 'h18F, 'h200, 'h232, 'h38F};
    localparam int T_MAG  [NT] = '{'h0001, 'h0002, 'h0004, 'h0007, 'h8000, 'hFFFF,
                                   'h00FF, 'h0060, 'h0006, 'h1000, 'h00FF, 'h4000};
    localparam int T_BAR  [NT] = '{0, 6, 12, 18, 90, 96, 48, 40, 16, 72, 48, 84};

    typedef struct {
        int kind;
        int val;
        int ch;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [9:0]  rd_addr_o;
    logic        rd_en_o;
    logic [15:0] rd_data;
    logic        wr_busy;
    logic        wr_start_o;
    logic [6:0]  wr_bar_o;
    logic        wr_lr_change_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        overrun_o;
    logic        ch_o;

    int checks   = 0;
    int failures = 0;
    ev_t ev_q[$];
    int  addr_q[$];
    logic [15:0] mem [0:1023];
    int busy_left;
    int w_starts = 0;
    int stall_at = -1;

    always #5 clk = ~clk;

    fft_bar_sequencer #(.NUM_BARS(NB), .BAR_MAX(96), .RD_LAT(1)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .frame_start_i  (frame_start),
        .rd_addr_o      (rd_addr_o),
        .rd_en_o        (rd_en_o),
        .rd_data_i      (rd_data),
        .wr_busy_i      (wr_busy),
        .wr_start_o     (wr_start_o),
        .wr_bar_o       (wr_bar_o),
        .wr_lr_change_o (wr_lr_change_o),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o),
        .overrun_o      (overrun_o),
        .ch_o           (ch_o)
    );

    // Magnitude RAM with one cycle read latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else if (rd_en_o) rd_data <= mem[rd_addr_o];
    end

    // Writer model: Busy rises the cycle after Start and stays high WR_LEN cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_left <= 0;
        end else if (wr_start_o) begin
            busy_left <= (w_starts == stall_at) ? 500 : WR_LEN;
            w_starts  <= w_starts + 1;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end
    end
    assign wr_busy = (busy_left > 0);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none at %0t", name, $time);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rd_addr"}, int'(rd_addr_o), 0);
        chk({name, "_rd_en"}, int'(rd_en_o), 0);
        chk({name, "_wr_start"}, int'(wr_start_o), 0);
        chk({name, "_wr_bar"}, int'(wr_bar_o), 0);
        chk({name, "_wr_lr"}, int'(wr_lr_change_o), 0);
        chk({name, "_busy"}, int'(busy_o), 0);
        chk({name, "_done"}, int'(frame_done_o), 0);
        chk({name, "_overrun"}, int'(overrun_o), 0);
        chk({name, "_ch"}, int'(ch_o), 0);
    endtask

    function automatic int exp_bar(input int addr);
        int b;
        b = 0;
        for (int i = 0; i < NT; i++) begin
            if (T_ADDR[i] == addr) b = T_BAR[i];
        end
        return b;
    endfunction

    task automatic push_frame();
        ev_t e;
        for (int c = 0; c < 2; c++) begin
            e.kind = EV_LR; e.val = 0; e.ch = c;
            ev_q.push_back(e);
            for (int i = 0; i < NB; i++) begin
                e.kind = EV_BAR; e.val = exp_bar(c * 512 + i); e.ch = c;
                ev_q.push_back(e);
                addr_q.push_back(c * 512 + i);
            end
        end
        e.kind = EV_DONE; e.val = 0; e.ch = 0;
        ev_q.push_back(e);
    endtask

    // Monitor: compare every emitted DUT event against the scoreboard head.
    ev_t mon_e;
    int  mon_a;
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_start_o && wr_lr_change_o) fail_now("start_lr_overlap");
            if (rd_en_o) begin
                if (addr_q.size() == 0) fail_now("unexpected_rd_en");
                else begin
                    mon_a = addr_q.pop_front();
                    chk("rd_addr", int'(rd_addr_o), mon_a);
                end
            end
            if (wr_lr_change_o) begin
                if (ev_q.size() == 0) fail_now("unexpected_lr_change");
                else begin
                    mon_e = ev_q.pop_front();
                    chk("lr_event_kind", EV_LR, mon_e.kind);
                end
            end
            if (wr_start_o) begin
                if (ev_q.size() == 0) fail_now("unexpected_wr_start");
                else begin
                    mon_e = ev_q.pop_front();
                    chk("start_event_kind", EV_BAR, mon_e.kind);
                    chk("wr_bar", int'(wr_bar_o), mon_e.val);
                    chk("ch_at_start", int'(ch_o), mon_e.ch);
                end
            end
            if (frame_done_o) begin
                if (ev_q.size() == 0) fail_now("unexpected_frame_done");
                else begin
                    mon_e = ev_q.pop_front();
                    chk("done_event_kind", EV_DONE, mon_e.kind);
                    chk("busy_at_done", int'(busy_o), 1);
                end
            end
        end
    end

    task automatic pulse_fs();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("busy_after_fs", int'(busy_o), 1);
    endtask

    task automatic wait_starts(input int target, input string name);
        int n;
        n = 0;
        while (w_starts < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (w_starts < target) fail_now({name, "_timeout"});
    endtask

    // Waits for FrameDone; optionally fires FrameStart in that same cycle.
    task automatic wait_done(input string name, input bit fs_at_done);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done_o && n < 20000);
        if (!frame_done_o) fail_now({name, "_done_timeout"});
        if (fs_at_done) frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk({name, "_busy_fall"}, int'(busy_o), 0);
        chk({name, "_queue_drained"}, ev_q.size() + addr_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int base, n, g;
        bit bad;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        for (int a = 0; a < 1024; a++) mem[a] = ((a % 512) < NB) ? 16'h0000 : 16'hFFFF;
        for (int i = 0; i < NT; i++) mem[T_ADDR[i]] = 16'(T_MAG[i]);

        repeat (3) @(negedge clk);
        chk_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("after_reset");

        // Frame 1: plain frame.
        push_frame();
        pulse_fs();
        wait_done("f1", 1'b0);
        chk("f1_overrun", int'(overrun_o), 0);

        // Frame 2: writer stalls 500 cycles on Left bar 10, FrameStart lands on FrameDone.
        stall_at = w_starts + 10;
        push_frame();
        pulse_fs();
        wait_starts(stall_at + 1, "stall_start");
        bad = 1'b0;
        n = 0;
        while (wr_busy && n < 600) begin
            if (wr_start_o || rd_en_o) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("stall_quiet", int'(bad), 0);
        // First low Busy cycle is WAITEND, then NEXT, READ, WAITRD, CALC, START.
        g = 0;
        while (!wr_start_o && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("restart_gap", g, 5);
        wait_done("f2", 1'b1);
        chk("overrun_at_done", int'(overrun_o), 1);
        repeat (20) @(negedge clk);
        chk("fs_at_done_ignored", int'(busy_o), 0);
        do_reset();
        chk_zero("reset_clears");

        // Frame 3: extra FrameStart mid-frame sets Overrun, frame unchanged.
        base = w_starts;
        push_frame();
        pulse_fs();
        chk("f3_overrun_before", int'(overrun_o), 0);
        wait_starts(base + 200, "mid_frame");
        pulse_fs();
        @(negedge clk);
        chk("f3_overrun_set", int'(overrun_o), 1);
        wait_done("f3", 1'b0);
        chk("f3_overrun_end", int'(overrun_o), 1);

        // Frame 4: Overrun stays sticky across a whole frame.
        push_frame();
        pulse_fs();
        wait_done("f4", 1'b0);
        chk("f4_overrun_sticky", int'(overrun_o), 1);

        // Frame 5: asynchronous reset during WAITEND of Right bar 50.
        base = w_starts;
        push_frame();
        pulse_fs();
        wait_starts(base + NB + 51, "right_bar50");
        @(negedge clk);
        chk("pre_reset_rd_addr", int'(rd_addr_o), 'h232);
        chk("pre_reset_wr_bar", int'(wr_bar_o), 48);
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        ev_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("after_async_reset");

        // Frame 6: clean restart from LRChange and address 0x000.
        push_frame();
        pulse_fs();
        wait_done("f6", 1'b0);
        chk("f6_overrun", int'(overrun_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
